morse_symbol_keyer: RTL and testbench

//   Morse transmit back end: turns one-cycle symbol requests into timed key levels.
//   It is the inverse of the level-to-pulse conditioning on the input side.
//   It accepts dot/dash/letter-gap/word-gap codes over a valid/ready handshake.
//   It drives key_out high for the mark time, then low for the spacing time.
//   It sits between the text-to-Morse encoder and the LED/buzzer output.

---
 rtl/morse_pkg.sv | 47 ++++
 rtl/morse_unit_timer.sv | 36 +++
 rtl/morse_symbol_keyer.sv | 125 ++++++++++++
 tb/tb_morse_symbol_keyer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse transmit back end.
//   Symbol codes presented on sym_code, FSM state encodings, and the
//   number of Morse time units each mark/space phase lasts.
package morse_pkg;

    typedef enum logic [1:0] {
        SYM_DOT  = 2'b00,
        SYM_DASH = 2'b01,
        SYM_LGAP = 2'b10,
        SYM_WGAP = 2'b11
    } sym_code_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_MARK  = 2'b01,
        ST_SPACE = 2'b10
    } state_t;

    localparam logic [2:0] DOT_U      = 3'd1;
    localparam logic [2:0] DASH_U     = 3'd3;
    localparam logic [2:0] ELEM_GAP_U = 3'd1;
    // Gap codes follow an element that already left one unit of spacing,
    // so 2 and 6 units make the usual totals of 3 and 7.
    localparam logic [2:0] LGAP_U     = 3'd2;
    localparam logic [2:0] WGAP_U     = 3'd6;

    // Key-down length of a symbol, in units (only dot/dash have a mark).
    function automatic logic [2:0] mark_units(input sym_code_t code);
        return (code == SYM_DASH) ? DASH_U : DOT_U;
    endfunction

    // Key-up length that closes a symbol, in units.
    function automatic logic [2:0] space_units(input sym_code_t code);
        logic [2:0] units;
        case (code)
            SYM_LGAP: units = LGAP_U;
            SYM_WGAP: units = WGAP_U;
            default:  units = ELEM_GAP_U;
        endcase
        return units;
    endfunction

    function automatic logic is_element(input sym_code_t code);
        return (code == SYM_DOT) || (code == SYM_DASH);
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Morse unit timer: divides clk down to one tick per Morse time unit.
//   clk     in  system clock
//   clrn    in  asynchronous active-low reset
//   restart in  clear the cycle count so the next unit starts fresh
//   tick    out high in the last cycle of each unit (every cycle when UNIT_CYCLES=1)
module morse_unit_timer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 4,
    parameter int CNT_W       = 26
) (
    input  logic clk,
    input  logic clrn,
    input  logic restart,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(UNIT_CYCLES - 1);

    logic [CNT_W-1:0] cyc;

    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cyc <= '0;
        end else if (restart || cyc == LAST) begin
            cyc <= '0;
        end else begin
            cyc <= cyc + CNT_W'(1);
        end
    end

    assign tick = (cyc == LAST);

endmodule

// File: rtl/morse_symbol_keyer.sv
// Morse symbol keyer: turns accepted dot/dash/letter-gap/word-gap requests
// into a timed key level (mark then space), one symbol at a time.
//   clk        in  system clock
//   clrn       in  asynchronous active-low reset (drops key_out immediately)
//   sym_valid  in  symbol request
//   sym_code   in  00 dot, 01 dash, 10 letter gap, 11 word gap
//   sym_ready  out high while idle; a request is taken when valid && ready
//   key_out    out registered key level, 1 = tone/LED on
//   busy       out a symbol is in progress
//   done       out one-cycle pulse in the idle cycle after a symbol completes
module morse_symbol_keyer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 4,
    parameter int CNT_W       = 26
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       sym_valid,
    input  logic [1:0] sym_code,
    output logic       sym_ready,
    output logic       key_out,
    output logic       busy,
    output logic       done
);

    state_t     state_q, state_d;
    sym_code_t  code_q, code_d;
    logic [2:0] units_q, units_d;
    logic       key_d;
    logic       done_d;
    logic       restart;
    logic       tick;

    morse_unit_timer #(
        .UNIT_CYCLES(UNIT_CYCLES),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk    (clk),
        .clrn   (clrn),
        .restart(restart),
        .tick   (tick)
    );

    // NOTE: every control register, key level included, sits on the async
    // reset so a reset mid-mark silences the key without waiting for clk.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= ST_IDLE;
            code_q  <= SYM_DOT;
            units_q <= '0;
            key_out <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            units_q <= units_d;
            key_out <= key_d;
            done    <= done_d;
        end
    end

    // The timer is held clear while idle and restarted on every phase
    // change, so each phase begins on a whole unit boundary.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        state_d = state_q;
        code_d  = code_q;
        units_d = units_q;
        key_d   = key_out;
        done_d  = 1'b0;
        restart = 1'b0;

        case (state_q)
            ST_IDLE: begin
                restart = 1'b1;
                key_d   = 1'b0;
                if (sym_valid) begin
                    code_d = sym_code_t'(sym_code);
                    if (is_element(sym_code_t'(sym_code))) begin
                        state_d = ST_MARK;
                        key_d   = 1'b1;
                        units_d = mark_units(sym_code_t'(sym_code));
                    end else begin
                        state_d = ST_SPACE;
                        units_d = space_units(sym_code_t'(sym_code));
                    end
                end
            end
            ST_MARK: begin
                if (tick) begin
                    if (units_q == 3'd1) begin
                        state_d = ST_SPACE;
                        key_d   = 1'b0;
                        units_d = space_units(code_q);
                        restart = 1'b1;
                    end else begin
                        units_d = units_q - 3'd1;
                    end
                end
            end
            ST_SPACE: begin
                if (tick) begin
                    if (units_q == 3'd1) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        restart = 1'b1;
                    end else begin
                        units_d = units_q - 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                key_d   = 1'b0;
                restart = 1'b1;
            end
        endcase
    end

    assign sym_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_morse_symbol_keyer.sv
// Bench for morse_symbol_keyer: three instances (UNIT_CYCLES = 4, 1, 7) share
// clock and reset. Stimulus pushes each accepted symbol's expected mark and
// space lengths into a per-instance queue; a monitor per instance measures
// key-high and key-low busy cycles and compares them on every done pulse.
module tb_morse_symbol_keyer;

    localparam int UC [3] = '{4, 1, 7};

    typedef struct {
        int mark;
        int space;
    } exp_t;

    logic       clk = 1'b0;
    logic       clrn;
    logic [2:0] valid;
    logic [1:0] code [3];
    wire  [2:0] rdy, key, bsy, dn;

    exp_t sb0 [$];
    exp_t sb1 [$];
    exp_t sb2 [$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        morse_symbol_keyer #(
            .UNIT_CYCLES(UC[g]),
            .CNT_W      (26)
        ) u_dut (
            .clk      (clk),
            .clrn     (clrn),
            .sym_valid(valid[g]),
            .sym_code (code[g]),
            .sym_ready(rdy[g]),
            .key_out  (key[g]),
            .busy     (bsy[g]),
            .done     (dn[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Hand model of symbol timing: dot U/U, dash 3U/U, letter gap 0/2U, word gap 0/6U.
    function automatic exp_t expect_of(input int u, input logic [1:0] c);
        exp_t e;
        case (c)
            2'b00:   begin e.mark = u;     e.space = u;     end
            2'b01:   begin e.mark = 3 * u; e.space = u;     end
            2'b10:   begin e.mark = 0;     e.space = 2 * u; end
            default: begin e.mark = 0;     e.space = 6 * u; end
        endcase
        return e;
    endfunction

    task automatic push(input int idx, input logic [1:0] c);
        exp_t e;
        e = expect_of(UC[idx], c);
        case (idx)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endtask

    function automatic int sb_size(input int idx);
        case (idx)
            0:       return sb0.size();
            1:       return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    function automatic exp_t sb_pop(input int idx);
        case (idx)
            0:       return sb0.pop_front();
            1:       return sb1.pop_front();
            default: return sb2.pop_front();
        endcase
    endfunction

    // Waits (bounded) for ready, presents one symbol for one edge.
    task automatic send(input int idx, input logic [1:0] c);
        int n = 0;
        @(negedge clk);
        while (!rdy[idx] && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[idx]) begin
            check("ready_timeout", {31'd0, rdy[idx]}, 1);
            return;
        end
        valid[idx] = 1'b1;
        code[idx]  = c;
        @(posedge clk);
        push(idx, c);
        #1 valid[idx] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb0.size() + sb1.size() + sb2.size() != 0 || bsy != 3'b000) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_pending", sb0.size() + sb1.size() + sb2.size(), 0);
    endtask

    task automatic monitor(input int idx);
        int   mark_n = 0;
        int   space_n = 0;
        logic prev_done = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!clrn) begin
                mark_n    = 0;
                space_n   = 0;
                prev_done = 1'b0;
            end else begin
                if (bsy[idx] && key[idx]) mark_n++;
                else if (bsy[idx]) space_n++;
                if (dn[idx]) begin
                    check($sformatf("u%0d_ready_at_done", UC[idx]), {31'd0, rdy[idx]}, 1);
                    check($sformatf("u%0d_done_one_cycle", UC[idx]), {31'd0, prev_done}, 0);
                    if (sb_size(idx) == 0) begin
                        check($sformatf("u%0d_unexpected_done", UC[idx]), {31'd0, dn[idx]}, 0);
                    end else begin
                        e = sb_pop(idx);
                        check($sformatf("u%0d_mark_cycles", UC[idx]), mark_n, e.mark);
                        check($sformatf("u%0d_space_cycles", UC[idx]), space_n, e.space);
                    end
                    mark_n  = 0;
                    space_n = 0;
                end
                prev_done = dn[idx];
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    initial begin
        clrn  = 1'b0;
        valid = 3'b000;
        for (int i = 0; i < 3; i++) code[i] = 2'b00;
        repeat (3) @(negedge clk);
        #2 clrn = 1'b1;

        // 1: quiet after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("reset_key", {31'd0, key[0]}, 0);
            check("reset_ready", {31'd0, rdy[0]}, 1);
            check("reset_busy", {31'd0, bsy[0]}, 0);
            check("reset_done", {31'd0, dn[0]}, 0);
        end

        // 2: single dot, cycle-exact
        send(0, 2'b00);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check($sformatf("dot_key_c%0d", i), {31'd0, key[0]}, (i <= 4) ? 1 : 0);
        end
        @(negedge clk);
        check("dot_done_t9", {31'd0, dn[0]}, 1);
        check("dot_ready_t9", {31'd0, rdy[0]}, 1);
        drain();

        // 3: dash then word gap, back-to-back
        send(0, 2'b01);
        send(0, 2'b11);
        drain();

        // 4: request held while busy yields exactly one dot
        @(negedge clk);
        valid[0] = 1'b1;
        code[0]  = 2'b00;
        @(posedge clk);
        push(0, 2'b00);
        repeat (3) @(posedge clk);
        #1 valid[0] = 1'b0;
        drain();

        // 5: async reset in cycle 6 of a dash, then a normal dot
        send(0, 2'b01);
        repeat (5) @(posedge clk);
        #3 clrn = 1'b0;
        #1;
        check("rst_mid_key", {31'd0, key[0]}, 0);
        check("rst_mid_busy", {31'd0, bsy[0]}, 0);
        check("rst_mid_ready", {31'd0, rdy[0]}, 1);
        sb0.delete();
        repeat (2) @(negedge clk);
        #2 clrn = 1'b1;
        send(0, 2'b00);
        drain();

        // 6: U=1 and U=7 with dot, dash, letter gap
        for (int idx = 1; idx < 3; idx++) begin
            send(idx, 2'b00);
            send(idx, 2'b01);
            send(idx, 2'b10);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
